// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, fetch FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;

  localparam logic [INSTR_WIDTH-1:0] NOP = 16'h0000;

  // 2'b11 is deliberately left unnamed; the FSM recovers from it to BOOT.
  typedef enum logic [1:0] {
    FS_BOOT = 2'b00,
    FS_RUN  = 2'b01,
    FS_HALT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / flush and a valid bit.
// Latency: one clock edge from load to outputs.
// Backpressure: holds all fields when neither load nor flush is asserted.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load                capture instr_in / pc_in, set valid
//   flush               clear valid and force instr to NOP (wins over load)
//   instr_in, pc_in     instruction word and its byte address
//   valid, instr, pc, pc_next  registered IF/ID contents
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    PC_STEP   = 16'd2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_next
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pc_next <= '0;
    end else if (flush) begin
      // The pc fields keep their old values; only valid/instr mark the bubble.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_in;
      pc      <= pc_in;
      pc_next <= pc_in + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address, fills IF/ID.
// Latency: instruction at pc=A appears on if_id_* one edge later; 1 instruction/cycle.
// Backpressure: stall freezes pc, IF/ID and fetch_count; a redirect still overrides a stall.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   stall                          downstream hold
//   redirect_valid, redirect_pc    taken branch/jump and its target (bit 0 ignored)
//   halt_req                       enter HALT after the current fetch
//   im_addr / im_data              combinational instruction memory interface
//   if_id_valid/instr/pc/pc_next   IF/ID pipeline register outputs
//   fetch_state                    00=BOOT 01=RUN 10=HALT
//   fetch_count                    number of valid captures, wraps
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = 16'h0000,
  parameter logic [PC_WIDTH-1:0]    PC_STEP   = 16'd2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt_req,
  output logic [PC_WIDTH-1:0]    im_addr,
  input  logic [INSTR_WIDTH-1:0] im_data,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_next,
  output logic [1:0]             fetch_state,
  output logic [15:0]            fetch_count
);

  fetch_state_t          state, state_d;
  logic [PC_WIDTH-1:0]   pc, pc_d;
  logic [PC_WIDTH-1:0]   redirect_aligned;
  logic                  load, flush, count_inc;

  // Masking rather than slicing keeps every redirect_pc bit in use.
  assign redirect_aligned = redirect_pc & ~{{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign im_addr          = pc;
  assign fetch_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (count_inc) fetch_count <= fetch_count + 16'd1;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    load      = 1'b0;
    flush     = 1'b0;
    count_inc = 1'b0;
    case (state)
      // One settle cycle after reset; stall/redirect are ignored here.
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_aligned;
          flush = 1'b1;
        end else if (!stall) begin
          load      = 1'b1;
          pc_d      = pc + PC_STEP;
          count_inc = 1'b1;
          // The word at pc is still captured: it is the last one fetched.
          if (halt_req) state_d = FS_HALT;
        end
      end
      FS_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned;
          flush   = 1'b1;
          state_d = FS_RUN;
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      default: state_d = FS_BOOT;
    endcase
  end

  if_id_reg #(
    .PC_STEP   (PC_STEP),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .instr_in (im_data),
    .pc_in    (pc),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .pc_next  (if_id_pc_next)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected snapshots, a monitor compares.
// Latency: each expectation targets the outputs visible after the next rising edge.
// Backpressure: n/a (bench).
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default RESET_PC
  logic        rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] im_addr, im_data, if_id_instr, if_id_pc, if_id_pc_next, fetch_count;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic        mem_mode = 1'b0;

  // DUT b: RESET_PC = 0xFFFC, inputs idle except reset
  logic        rst_b = 1'b1;
  logic        stall_b = 1'b0, redirect_valid_b = 1'b0, halt_req_b = 1'b0;
  logic [15:0] redirect_pc_b = 16'h0000;
  logic [15:0] im_addr_b, im_data_b, if_id_instr_b, if_id_pc_b, if_id_pc_next_b, fetch_count_b;
  logic        if_id_valid_b;
  logic [1:0]  fetch_state_b;

  // Memory model: constant 0x1212, or address XOR 0xA000.
  assign im_data   = mem_mode ? (im_addr ^ 16'hA000) : 16'h1212;
  assign im_data_b = im_addr_b ^ 16'hA000;

  fetch_unit u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .im_addr(im_addr), .im_data(im_data),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_next(if_id_pc_next), .fetch_state(fetch_state), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) u_dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .redirect_valid(redirect_valid_b),
    .redirect_pc(redirect_pc_b), .halt_req(halt_req_b), .im_addr(im_addr_b), .im_data(im_data_b),
    .if_id_valid(if_id_valid_b), .if_id_instr(if_id_instr_b), .if_id_pc(if_id_pc_b),
    .if_id_pc_next(if_id_pc_next_b), .fetch_state(fetch_state_b), .fetch_count(fetch_count_b)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic [15:0] addr;
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcn;
    logic [15:0] cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Monitor: compare every expectation due on this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      e = q_a.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL a_stale: got cycle %0d expected cycle %0d", cyc, e.cyc);
      end else begin
        chk("a_state", e.cyc, {14'd0, fetch_state}, {14'd0, e.st});
        chk("a_im_addr", e.cyc, im_addr, e.addr);
        chk("a_valid", e.cyc, {15'd0, if_id_valid}, {15'd0, e.v});
        chk("a_instr", e.cyc, if_id_instr, e.instr);
        chk("a_pc", e.cyc, if_id_pc, e.pc);
        chk("a_pc_next", e.cyc, if_id_pc_next, e.pcn);
        chk("a_count", e.cyc, fetch_count, e.cnt);
      end
    end
    while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      e = q_b.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL b_stale: got cycle %0d expected cycle %0d", cyc, e.cyc);
      end else begin
        chk("b_state", e.cyc, {14'd0, fetch_state_b}, {14'd0, e.st});
        chk("b_im_addr", e.cyc, im_addr_b, e.addr);
        chk("b_valid", e.cyc, {15'd0, if_id_valid_b}, {15'd0, e.v});
        chk("b_instr", e.cyc, if_id_instr_b, e.instr);
        chk("b_pc", e.cyc, if_id_pc_b, e.pc);
        chk("b_pc_next", e.cyc, if_id_pc_next_b, e.pcn);
        chk("b_count", e.cyc, fetch_count_b, e.cnt);
      end
    end
  end

  // Drive DUT a inputs for the next edge and push the outputs expected after it.
  task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rpc,
                      input logic h, input logic mm, input logic [1:0] st, input logic [15:0] addr,
                      input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic [15:0] pcn, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk); #1;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = h; mem_mode = mm;
    e.cyc = cyc + 1; e.st = st; e.addr = addr; e.v = v; e.instr = ins;
    e.pc = pc; e.pcn = pcn; e.cnt = cnt;
    q_a.push_back(e);
  endtask

  task automatic step_b(input logic r, input logic [1:0] st, input logic [15:0] addr,
                        input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic [15:0] pcn, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk); #1;
    rst_b = r;
    e.cyc = cyc + 1; e.st = st; e.addr = addr; e.v = v; e.instr = ins;
    e.pc = pc; e.pcn = pcn; e.cnt = cnt;
    q_b.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst stl rv rpc      hlt mm  st    addr     v  instr    pc       pcn      cnt
    // reset and boot
    step(1, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    step(1, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    step(0, 0, 0, 16'h0000, 0, 0, 2'd1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    // sequential fetch from constant memory
    step(0, 0, 0, 16'h0000, 0, 0, 2'd1, 16'h0002, 1, 16'h1212, 16'h0000, 16'h0002, 16'd1);
    step(0, 0, 0, 16'h0000, 0, 0, 2'd1, 16'h0004, 1, 16'h1212, 16'h0002, 16'h0004, 16'd2);
    // stall 3 cycles at pc 0x0004
    step(0, 1, 0, 16'h0000, 0, 0, 2'd1, 16'h0004, 1, 16'h1212, 16'h0002, 16'h0004, 16'd2);
    step(0, 1, 0, 16'h0000, 0, 0, 2'd1, 16'h0004, 1, 16'h1212, 16'h0002, 16'h0004, 16'd2);
    step(0, 1, 0, 16'h0000, 0, 0, 2'd1, 16'h0004, 1, 16'h1212, 16'h0002, 16'h0004, 16'd2);
    step(0, 0, 0, 16'h0000, 0, 1, 2'd1, 16'h0006, 1, 16'hA004, 16'h0004, 16'h0006, 16'd3);
    // redirect to odd 0x0101 while stalled: flush, pc 0x0100
    step(0, 1, 1, 16'h0101, 0, 1, 2'd1, 16'h0100, 0, 16'h0000, 16'h0004, 16'h0006, 16'd3);
    step(0, 0, 0, 16'h0000, 0, 1, 2'd1, 16'h0102, 1, 16'hA100, 16'h0100, 16'h0102, 16'd4);
    step(0, 0, 0, 16'h0000, 0, 1, 2'd1, 16'h0104, 1, 16'hA102, 16'h0102, 16'h0104, 16'd5);
    // go to 0x0010, halt_req ignored under stall, then taken
    step(0, 0, 1, 16'h0010, 0, 1, 2'd1, 16'h0010, 0, 16'h0000, 16'h0102, 16'h0104, 16'd5);
    step(0, 1, 0, 16'h0000, 1, 1, 2'd1, 16'h0010, 0, 16'h0000, 16'h0102, 16'h0104, 16'd5);
    step(0, 0, 0, 16'h0000, 1, 1, 2'd2, 16'h0012, 1, 16'hA010, 16'h0010, 16'h0012, 16'd6);
    // HALT: bubble, then hold under stall
    step(0, 0, 0, 16'h0000, 0, 1, 2'd2, 16'h0012, 0, 16'h0000, 16'h0010, 16'h0012, 16'd6);
    step(0, 1, 0, 16'h0000, 0, 1, 2'd2, 16'h0012, 0, 16'h0000, 16'h0010, 16'h0012, 16'd6);
    // redirect out of HALT to 0x0040
    step(0, 0, 1, 16'h0040, 0, 1, 2'd1, 16'h0040, 0, 16'h0000, 16'h0010, 16'h0012, 16'd6);
    step(0, 0, 0, 16'h0000, 0, 1, 2'd1, 16'h0042, 1, 16'hA040, 16'h0040, 16'h0042, 16'd7);
    step(0, 0, 0, 16'h0000, 1, 1, 2'd2, 16'h0044, 1, 16'hA042, 16'h0042, 16'h0044, 16'd8);
    // reset during a redirect in HALT wins
    step(1, 0, 1, 16'h0080, 0, 1, 2'd0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    // BOOT ignores redirect and stall, lasts one cycle
    step(0, 1, 1, 16'h0080, 0, 1, 2'd1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    step(0, 0, 0, 16'h0000, 0, 1, 2'd1, 16'h0002, 1, 16'hA000, 16'h0000, 16'h0002, 16'd1);

    // DUT b: wrap-around from RESET_PC 0xFFFC
    step_b(1, 2'd0, 16'hFFFC, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    step_b(0, 2'd1, 16'hFFFC, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    step_b(0, 2'd1, 16'hFFFE, 1, 16'h5FFC, 16'hFFFC, 16'hFFFE, 16'd1);
    step_b(0, 2'd1, 16'h0000, 1, 16'h5FFE, 16'hFFFE, 16'h0000, 16'd2);
    step_b(0, 2'd1, 16'h0002, 1, 16'hA000, 16'h0000, 16'h0002, 16'd3);

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of Instruction_memory.
- Owns the program counter and drives the memory's byte address. Captures the combinational 16-bit instruction word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, halt, and a retired-fetch counter.
- Instructions are 16 bits at byte addresses, so the sequential PC step is 2.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch.
- NOP_INSTR, 16'h0000, value driven on if_id_instr whenever if_id_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream hold; freezes PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  16  target byte address; bit 0 forced to 0 internally.
- halt_req  in  1  enter HALT after the current fetch.
- im_addr  out  16  address to Instruction_memory; always equals pc (combinational).
- im_data  in  16  instruction word returned combinationally, same cycle.
- if_id_valid  out  1  IF/ID entry holds a real instruction.
- if_id_instr  out  16  captured instruction.
- if_id_pc  out  16  address of the captured instruction.
- if_id_pc_next  out  16  if_id_pc + PC_STEP, mod 2^16.
- fetch_state  out  2  00=BOOT, 01=RUN, 10=HALT.
- fetch_count  out  16  number of instructions written into IF/ID with valid=1; wraps.

Behaviour:
- Reset (any state, any cycle, including mid-stall or mid-redirect):
  - pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_next=0, fetch_count=0.
- BOOT: lasts exactly one cycle, so memory output settles after reset. It issues no capture, and state moves to RUN on the next edge. stall and redirect inputs are ignored in BOOT.
- RUN, per rising edge, first match wins:
  1. redirect_valid=1: pc <= {redirect_pc[15:1],1'b0}; if_id_valid <= 0; if_id_instr <= NOP_INSTR. This happens even when stall=1 (redirect beats stall), and the wrong-path word is discarded.
  2. stall=1: pc and all IF/ID fields hold; fetch_count holds.
  3. Otherwise: if_id_instr <= im_data; if_id_pc <= pc; if_id_pc_next <= pc+PC_STEP; if_id_valid <= 1; pc <= pc+PC_STEP; fetch_count <= fetch_count+1. If halt_req=1 on this same edge, state <= HALT. The capture still happens, so the instruction at pc is the last one fetched.
- halt_req during stall is ignored until the stall drops; it must be held by its source.
- HALT:
  - pc holds, and the next edge clears if_id_valid (bubble) unless stall=1.
  - redirect_valid=1 loads the PC as in rule 1 and returns state to RUN.
  - Only rst or a redirect leaves HALT.
- Latency: instruction at address A appears on if_id_* one edge after pc=A with no stall. Throughput is 1 instruction/cycle.
- PC wrap: 0xFFFE + 2 = 0x0000 with no error. if_id_pc_next wraps the same way.
- pc[0] is always 0.
- if_id_instr equals NOP_INSTR whenever if_id_valid=0.
- Encoding 2'b11 for fetch_state is unreachable; if reached, the next edge goes to BOOT.

Decomposition:
- Shared package cpu_pkg:
  - fetch-state constants FS_BOOT/FS_RUN/FS_HALT.
  - PC_WIDTH=16, INSTR_WIDTH=16.
  - NOP encoding.
- Natural sub-module: if_id_reg, the pipeline register with load/hold/flush controls and the valid bit. The PC/FSM/counter logic stays in fetch_unit.

Test Plan:
- Reset then run (pc_ mem filled with 16'h1212, no stall): fetch_state BOOT for 1 cycle, then RUN.
  - First valid output is if_id_pc=0x0000, instr=0x1212, pc_next=0x0002.
  - Then 0x0002, 0x0004 on consecutive cycles; fetch_count = 3 after 3 captures.
- stall held 3 cycles while pc=0x0004: im_addr stays 0x0004, if_id_* frozen, fetch_count frozen. The first post-stall capture is pc 0x0004.
- redirect_valid with redirect_pc=0x0101 concurrent with stall=1:
  - Next edge: if_id_valid=0, instr=NOP_INSTR, im_addr=0x0100.
  - The following edge captures if_id_pc=0x0100.
- RESET_PC=0xFFFC, run 3 fetches: if_id_pc sequence 0xFFFC, 0xFFFE, 0x0000; if_id_pc_next of 0xFFFE is 0x0000.
- halt_req pulse with pc=0x0010:
  - The instruction at 0x0010 is captured and state becomes HALT.
  - Next edge: if_id_valid=0, pc stays 0x0012.
  - redirect to 0x0040 resumes RUN, with first capture at 0x0040.
- rst asserted mid-redirect in HALT: all outputs return to reset values, and BOOT lasts 1 cycle.
